// File: rtl/pipelined_zero_detect_pkg.sv
// rtl/pipelined_zero_detect_pkg.sv - shared constants and tree-sizing helpers for reduction pipelines
package pipelined_zero_detect_pkg;

  localparam logic MODE_NZ = 1'b0;
  localparam logic MODE_EQ = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Number of pairwise-reduction levels needed to fold WIDTH bits to one.
  function automatic int tree_depth(input int width);
    return clog2(width);
  endfunction

  // Number of register stages when each stage absorbs up to lps levels.
  function automatic int tree_stages(input int width, input int lps);
    return (tree_depth(width) + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/pipelined_zero_detect_or_reduce_level.sv
// rtl/pipelined_zero_detect_or_reduce_level.sv - one OR-tree level folding adjacent bit pairs
module or_reduce_level #(
  parameter int IN_W = 2
) (
  input  logic [IN_W-1:0]   din,
  output logic [IN_W/2-1:0] dout
);

  // Bit i of the narrower vector is the OR of bits 2i and 2i+1.
  always_comb begin
    dout = '0;
    for (int i = 0; i < IN_W / 2; i++) begin
      dout[i] = din[2*i] | din[2*i+1];
    end
  end

endmodule

// File: rtl/pipelined_zero_detect.sv
// rtl/pipelined_zero_detect.sv - pipelined nonzero/equality detector with tag sideband and handshakes
module pipelined_zero_detect
  import pipelined_zero_detect_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_nonzero,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int DEPTH  = tree_depth(WIDTH);
  localparam int STAGES = tree_stages(WIDTH, LEVELS_PER_STAGE);

  logic              adv;
  logic [STAGES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [WIDTH-1:0]  vec0;
  logic              zero_q;

  // The whole pipe moves in lockstep; it only freezes when a finished result is refused.
  assign adv      = !valid_q[STAGES-1] | out_ready;
  assign in_ready = adv;
  assign vec0     = (in_mode == MODE_EQ) ? (in_a ^ in_b) : in_a;

  // Valid bits shift with the pipe (bubbles included); tags follow only valid entries.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) tag_q[s] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q[0] <= in_valid;
      if (in_valid) tag_q[0] <= in_tag;
      for (int s = 1; s < STAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
        if (valid_q[s-1]) tag_q[s] <= tag_q[s-1];
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO    = s * LEVELS_PER_STAGE;
    localparam int HI    = (LO + LEVELS_PER_STAGE > DEPTH) ? DEPTH : LO + LEVELS_PER_STAGE;
    localparam int IN_W  = WIDTH >> LO;
    localparam int OUT_W = WIDTH >> HI;

    logic [IN_W-1:0]  stage_in;
    logic [OUT_W-1:0] stage_out;
    logic [OUT_W-1:0] data_q;
    logic             prev_valid;

    if (s == 0) begin : g_first
      assign stage_in   = vec0;
      assign prev_valid = in_valid;
    end else begin : g_next
      assign stage_in   = g_stage[s-1].data_q;
      assign prev_valid = valid_q[s-1];
    end

    for (genvar k = 0; k < HI - LO; k++) begin : g_lvl
      logic [(IN_W>>(k+1))-1:0] lout;
      if (k == 0) begin : g_src
        or_reduce_level #(.IN_W(IN_W)) u_lvl (.din(stage_in), .dout(lout));
      end else begin : g_src
        or_reduce_level #(.IN_W(IN_W >> k)) u_lvl (.din(g_lvl[k-1].lout), .dout(lout));
      end
    end

    assign stage_out = g_lvl[HI-LO-1].lout;

    // Partial vector only loads from a valid predecessor so outputs keep the last real result.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_q <= '0;
      end else if (!flush && adv && prev_valid) begin
        data_q <= stage_out;
      end
    end

    if (s == STAGES - 1) begin : g_last
      // Registered complement so out_zero is 0 after reset rather than the inverse of out_nonzero.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          zero_q <= 1'b0;
        end else if (!flush && adv && prev_valid) begin
          zero_q <= ~stage_out[0];
        end
      end
    end
  end

  assign out_valid   = valid_q[STAGES-1];
  assign out_nonzero = g_stage[STAGES-1].data_q[0];
  assign out_zero    = zero_q;
  assign out_tag     = tag_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_zero_detect.sv
// tb/tb_pipelined_zero_detect.sv - scoreboard bench for pipelined_zero_detect at three geometries
module tb_pipelined_zero_detect;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
  localparam int LAT_C = 2;

  typedef struct {
    logic       nz;
    logic [4:0] tag;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit lat_chk  = 0;

  logic clock   = 0;
  logic reset_n = 0;

  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_in_mode = 0;
  logic [31:0] a_in_a = 0, a_in_b = 0;
  logic [4:0]  a_in_tag = 0, a_out_tag;
  logic        a_out_valid, a_out_ready = 1, a_out_nonzero, a_out_zero;

  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_nonzero, b_out_zero;
  logic [7:0]  b_in_a = 0;
  logic [4:0]  b_in_tag = 0, b_out_tag;

  logic        c_in_valid = 0, c_in_ready, c_out_valid, c_out_nonzero, c_out_zero;
  logic [63:0] c_in_a = 0;
  logic [4:0]  c_in_tag = 0, c_out_tag;

  pipelined_zero_detect #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(5)) u_a (
    .clock(clock), .reset_n(reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_a(a_in_a), .in_b(a_in_b), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_nonzero(a_out_nonzero), .out_zero(a_out_zero), .out_tag(a_out_tag)
  );

  pipelined_zero_detect #(.WIDTH(8), .LEVELS_PER_STAGE(3), .TAG_W(5)) u_b (
    .clock(clock), .reset_n(reset_n), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(1'b0),
    .in_a(b_in_a), .in_b(8'h00), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(1'b1),
    .out_nonzero(b_out_nonzero), .out_zero(b_out_zero), .out_tag(b_out_tag)
  );

  pipelined_zero_detect #(.WIDTH(64), .LEVELS_PER_STAGE(4), .TAG_W(5)) u_c (
    .clock(clock), .reset_n(reset_n), .flush(1'b0),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_mode(1'b0),
    .in_a(c_in_a), .in_b(64'h0), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(1'b1),
    .out_nonzero(c_out_nonzero), .out_zero(c_out_zero), .out_tag(c_out_tag)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) check("a_spurious_result", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_nonzero", a_out_nonzero, e.nz);
          check("a_zero", a_out_zero, !e.nz);
          check("a_tag", a_out_tag, e.tag);
          if (lat_chk) check("a_latency", cyc - e.cyc, LAT_A);
        end
      end
      if (a_flush) qa.delete();
      else if (a_in_valid && a_in_ready) begin
        e.nz  = |(a_in_mode ? (a_in_a ^ a_in_b) : a_in_a);
        e.tag = a_in_tag;
        e.cyc = cyc;
        qa.push_back(e);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (b_out_valid) begin
        if (qb.size() == 0) check("b_spurious_result", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_nonzero", b_out_nonzero, e.nz);
          check("b_zero", b_out_zero, !e.nz);
          check("b_tag", b_out_tag, e.tag);
          if (lat_chk) check("b_latency", cyc - e.cyc, LAT_B);
        end
      end
      if (b_in_valid && b_in_ready) begin
        e.nz = |b_in_a; e.tag = b_in_tag; e.cyc = cyc;
        qb.push_back(e);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (c_out_valid) begin
        if (qc.size() == 0) check("c_spurious_result", 1, 0);
        else begin
          e = qc.pop_front();
          check("c_nonzero", c_out_nonzero, e.nz);
          check("c_zero", c_out_zero, !e.nz);
          check("c_tag", c_out_tag, e.tag);
          if (lat_chk) check("c_latency", cyc - e.cyc, LAT_C);
        end
      end
      if (c_in_valid && c_in_ready) begin
        e.nz = |c_in_a; e.tag = c_in_tag; e.cyc = cyc;
        qc.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_a(input logic mode, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    logic acc;
    int   n;
    a_in_valid = 1; a_in_mode = mode; a_in_a = a; a_in_b = b; a_in_tag = tag;
    n = 0;
    do begin
      @(negedge clock);
      acc = a_in_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("a_accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("drain_pending", qa.size() + qb.size() + qc.size(), 0);
  endtask

  initial begin
    repeat (2) step();
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_nonzero", a_out_nonzero, 0);
    check("rst_out_zero", a_out_zero, 0);
    check("rst_out_tag", a_out_tag, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_c_out_valid", c_out_valid, 0);
    reset_n = 1;
    lat_chk = 1;

    send_a(1'b0, 32'h0000_0000, 32'h0, 5'd1);
    send_a(1'b0, 32'h8000_0000, 32'h0, 5'd2);
    a_in_valid = 0;
    wait_drain();

    send_a(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd7);
    send_a(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 5'd8);
    send_a(1'b0, 32'hFFFF_FFFF, 32'h0, 5'd9);
    a_in_valid = 0;
    wait_drain();

    lat_chk = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [31:0] va;
          va = (i == 0) ? 32'h0 : ($urandom | 32'h1);
          send_a(logic'(i % 2), va, (i == 3) ? va : ~va, 5'(10 + i));
        end
        a_in_valid = 0;
      end
      begin
        int n;
        n = 0;
        @(negedge clock);
        while (!a_out_valid && n < 20) begin
          @(negedge clock);
          n++;
        end
        check("bp_first_result", a_out_valid, 1);
        step();
        a_out_ready = 0;
        repeat (4) begin
          @(negedge clock);
          check("bp_in_ready", a_in_ready, 0);
          check("bp_out_valid", a_out_valid, 1);
          check("bp_hold_nonzero", a_out_nonzero, qa[0].nz);
          check("bp_hold_tag", a_out_tag, qa[0].tag);
        end
        step();
        a_out_ready = 1;
      end
    join
    wait_drain();
    lat_chk = 1;

    send_a(1'b0, 32'h0000_0010, 32'h0, 5'd20);
    send_a(1'b0, 32'h0000_0000, 32'h0, 5'd21);
    send_a(1'b1, 32'h1234_5678, 32'h1234_5679, 5'd22);
    a_flush = 1; a_in_valid = 1; a_in_mode = 0; a_in_a = 32'h4; a_in_tag = 5'd23;
    step();
    a_flush = 0; a_in_valid = 0;
    check("flush_out_valid", a_out_valid, 0);
    step();
    check("flush_still_empty", a_out_valid, 0);
    send_a(1'b0, 32'h0001_0000, 32'h0, 5'd24);
    a_in_valid = 0;
    wait_drain();

    send_a(1'b0, 32'h0000_0001, 32'h0, 5'd25);
    send_a(1'b0, 32'h0000_0000, 32'h0, 5'd26);
    send_a(1'b0, 32'h0000_0004, 32'h0, 5'd27);
    a_in_valid = 0;
    #3;
    reset_n = 0;
    qa.delete();
    #1;
    check("arst_out_valid", a_out_valid, 0);
    check("arst_out_nonzero", a_out_nonzero, 0);
    check("arst_out_zero", a_out_zero, 0);
    check("arst_out_tag", a_out_tag, 0);
    step();
    reset_n = 1;
    send_a(1'b0, 32'h0000_0010, 32'h0, 5'd28);
    a_in_valid = 0;
    wait_drain();

    for (int i = 0; i < 66; i++) begin
      b_in_valid = (i < 10);
      b_in_a     = (i < 8) ? 8'(1 << i) : ((i == 8) ? 8'h00 : 8'hFF);
      b_in_tag   = 5'(i);
      c_in_valid = 1;
      c_in_a     = (i < 64) ? (64'h1 << i) : ((i == 64) ? 64'h0 : {64{1'b1}});
      c_in_tag   = 5'(i);
      step();
    end
    b_in_valid = 0;
    c_in_valid = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_zero_detect.md
Name: pipelined_zero_detect

Overview:
Parametrised, pipelined successor to the team's 32-bit combinational nonzero detector. Reduces a WIDTH-bit operand (mode 0), or the XOR of two operands for equality (mode 1), through a balanced OR tree with a register every LEVELS_PER_STAGE tree levels. Carries a tag alongside each result. Sits between the ALU operand latch and the branch-resolution logic (bne/blt/bex), with valid/ready handshakes on both sides so it tolerates backpressure from branch resolution.

Parameters:
WIDTH, 32, operand width; power of two, >= 2
LEVELS_PER_STAGE, 2, OR-tree levels per pipeline stage; >= 1
TAG_W, 5, width of sideband tag (e.g. destination register index)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline kill; clears all valid bits
in_valid  input  1  input operand valid
in_ready  output  1  block can accept input this cycle
in_mode  input  1  0 = reduce in_a; 1 = reduce in_a ^ in_b
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (ignored in mode 0)
in_tag  input  TAG_W  sideband, returned unchanged with the result
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_nonzero  output  1  1 iff the reduced vector has any bit set
out_zero  output  1  complement of out_nonzero while out_valid=1
out_tag  output  TAG_W  tag of the current result

Behaviour:
- DEPTH = log2(WIDTH). STAGES = ceil(DEPTH / LEVELS_PER_STAGE). Latency from input handshake to out_valid = STAGES cycles when not stalled.
- Stage 0 input vector: in_mode ? (in_a ^ in_b) : in_a, computed combinationally before the first tree level.
- Each tree level ORs adjacent pairs: bit i of level k+1 = bit 2i | bit 2i+1 of level k. The final stage holds a 1-bit result.
- Each stage register holds the partial vector, a valid bit, and the tag.
- Global advance: adv = !out_valid | out_ready. in_ready = adv.
  - adv=1: all stages shift by one; stage 0 loads on (in_valid & in_ready).
  - adv=0: all stages hold.
  - Bubbles are not compressed.
- Input accepted iff in_valid & in_ready. The upstream must hold its inputs while in_ready=0.
- Output handshake: the result is consumed on out_valid & out_ready. Outputs stay stable while out_valid=1 and out_ready=0.
- flush=1: on the next edge, every valid bit is cleared, including the output stage. Data and tag registers hold their values. An input presented in the same cycle as flush is dropped, and in_ready still reflects adv. flush overrides advance.
- Reset (reset_n=0, asynchronous): all valid bits=0, all data and tag registers=0, out_nonzero=0, out_zero=0, out_tag=0. The first edge after deassertion behaves as normal with an empty pipeline.
- out_nonzero and out_zero are registered. When the final stage loads, out_zero = ~reduced bit and out_nonzero = reduced bit. When no valid result exists, both hold their last loaded values.
- Throughput: one result per cycle when out_ready is held at 1.
- Boundary cases:
  - all-zero and all-one operands;
  - DEPTH not divisible by LEVELS_PER_STAGE (the last stage holds fewer levels);
  - LEVELS_PER_STAGE >= DEPTH, giving a single stage with latency 1.

Decomposition:
- Shared package:
  - MODE_NZ=1'b0, MODE_EQ=1'b1 constants;
  - clog2 function;
  - derived DEPTH and STAGES calculation, reused by future reduction blocks (leading-zero count, parity).
- Sub-module or_reduce_level (parameter IN_W): purely combinational; IN_W inputs reduced to IN_W/2 outputs via pairwise OR. Instantiated once per tree level in a generate loop. Stage registers live in the top level.

Test Plan:
- Defaults (WIDTH=32, LEVELS_PER_STAGE=2, STAGES=3), out_ready=1; mode 0 with a=0x00000000 then a=0x80000000 on consecutive cycles -> out_valid rises at cycles +3 and +4; out_zero=1/0 then 0/1 (out_zero/out_nonzero); tags preserved.
- Mode 1 with a=b=0xDEADBEEF, tag=7 -> out_zero=1, out_tag=7. Next input a=0xDEADBEEF, b=0xDEADBEEE -> out_nonzero=1.
- Backpressure: stream 6 operands, out_ready=0 for 4 cycles after the first result -> in_ready=0 during the stall, outputs stable, no loss or duplication; results emerge in order once out_ready=1.
- flush while 3 results are in flight and one input is offered -> out_valid=0 the next cycle; that input is never output; the next accepted input appears after 3 cycles.
- reset_n asserted asynchronously mid-stream (between clock edges) -> out_valid, out_nonzero, out_zero and out_tag go to 0 immediately; after release, the first result appears 3 cycles after the first accepted input.
- Parameter sweep: WIDTH=8 with LEVELS_PER_STAGE=3 (1 stage), and WIDTH=64 with LEVELS_PER_STAGE=4 (2 stages), each with a walking-one operand across all bit positions -> out_nonzero=1 for every position at the computed latency; all-zero operand -> out_zero=1.
